// File: rtl/apb_slave_bank.sv
// APB target with scratch RF, down-counting timer and data FIFO; `APB_SEL_CHECK_EN adds sel_err.
// Latency: prdata registered at the read SETUP edge; writes and pops commit at the ACCESS edge.
// Backpressure: none, zero wait states; FIFO drops pushes when full and flags sticky errors.
module apb_slave_bank #(
  parameter int unsigned RF_WORDS   = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] RD_DEFAULT = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [2:0]  pselx,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        timer_irq,
  output logic        fifo_full,
`ifdef APB_SEL_CHECK_EN
  output logic        sel_err,
`endif
  output logic        fifo_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic       psel, setup, setup_q, access, wr_en, rd_setup, rd_access;
  logic       sel_ok, sel_rf, sel_tm, sel_ff;
  logic [3:0] idx;
  logic       unused_addr;

  assign psel        = |pselx;
  assign idx         = paddr[5:2];
  assign unused_addr = ^{paddr[31:6], paddr[1:0]};

`ifdef APB_SEL_CHECK_EN
  assign sel_ok = (pselx & (pselx - 3'd1)) == 3'd0;
`else
  assign sel_ok = 1'b1;
`endif
  assign sel_rf = sel_ok & pselx[0];
  assign sel_tm = sel_ok & pselx[1] & ~pselx[0];
  assign sel_ff = sel_ok & pselx[2] & ~|pselx[1:0];

  // ACCESS only counts when the previous cycle was a SETUP.
  assign setup     = psel & ~penable;
  assign access    = psel & penable & setup_q;
  assign wr_en     = access & pwrite;
  assign rd_setup  = setup & ~pwrite;
  assign rd_access = access & ~pwrite;

  always_ff @(posedge hclk) begin
    if (hreset) setup_q <= 1'b0;
    else        setup_q <= setup;
  end

`ifdef APB_SEL_CHECK_EN
  always_ff @(posedge hclk) begin
    if (hreset)              sel_err <= 1'b0;
    else if (psel && !sel_ok) sel_err <= 1'b1;
  end
`endif

  logic [31:0] rf [RF_WORDS];
  logic        rf_hit;
  assign rf_hit = sel_rf & ({1'b0, idx} < 5'(RF_WORDS));

  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < RF_WORDS; i++) rf[i] <= '0;
    end else if (wr_en && rf_hit) begin
      rf[idx] <= pwdata;
    end
  end

  logic [2:0]  tm_ctrl;
  logic [31:0] tm_load, tm_count;
  logic        tm_expired, tm_wr_ctrl, tm_wr_load, tm_wr_stat;
  assign tm_wr_ctrl = wr_en & sel_tm & (idx == 4'd0);
  assign tm_wr_load = wr_en & sel_tm & (idx == 4'd1);
  assign tm_wr_stat = wr_en & sel_tm & (idx == 4'd3);
  assign timer_irq  = tm_expired & tm_ctrl[2];

  // Later assignments win: expiry beats W1C, register writes beat the tick.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      tm_ctrl    <= '0;
      tm_load    <= '0;
      tm_count   <= '0;
      tm_expired <= 1'b0;
    end else begin
      if (tm_wr_stat && pwdata[0]) tm_expired <= 1'b0;
      if (tm_ctrl[0]) begin
        if (tm_count != '0) begin
          tm_count <= tm_count - 32'd1;
        end else begin
          tm_expired <= 1'b1;
          if (tm_ctrl[1]) tm_count   <= tm_load;
          else            tm_ctrl[0] <= 1'b0;
        end
      end
      if (tm_wr_ctrl) tm_ctrl <= pwdata[2:0];
      if (tm_wr_load) begin
        tm_load  <= pwdata;
        tm_count <= pwdata;
      end
    end
  end

  logic [31:0]   ff_mem [FIFO_DEPTH];
  logic [AW-1:0] ff_wp, ff_rp;
  logic [CW-1:0] ff_cnt, ff_cnt_nxt;
  logic [3:0]    ff_cnt4;
  logic          ff_ovf, ff_udf, ff_push, ff_pop, ff_clr, do_push, do_pop;
  assign ff_push = wr_en & sel_ff & (idx == 4'd0);
  assign ff_pop  = rd_access & sel_ff & (idx == 4'd0);
  assign ff_clr  = wr_en & sel_ff & (idx == 4'd1);
  assign do_push = ff_push & ~fifo_full;
  assign do_pop  = ff_pop & ~fifo_empty;
  assign ff_cnt4 = 4'(ff_cnt);

  always_comb begin
    ff_cnt_nxt = ff_cnt;
    if (do_push)     ff_cnt_nxt = ff_cnt + CW'(1);
    else if (do_pop) ff_cnt_nxt = ff_cnt - CW'(1);
  end

  always_ff @(posedge hclk) begin
    if (do_push && !hreset) ff_mem[ff_wp] <= pwdata;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ff_wp      <= '0;
      ff_rp      <= '0;
      ff_cnt     <= '0;
      ff_ovf     <= 1'b0;
      ff_udf     <= 1'b0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (do_push) ff_wp <= ff_wp + AW'(1);
      if (do_pop)  ff_rp <= ff_rp + AW'(1);
      ff_cnt     <= ff_cnt_nxt;
      fifo_full  <= (ff_cnt_nxt == CW'(FIFO_DEPTH));
      fifo_empty <= (ff_cnt_nxt == '0);
      if (ff_clr) begin
        ff_ovf <= 1'b0;
        ff_udf <= 1'b0;
      end
      if (ff_push && fifo_full)  ff_ovf <= 1'b1;
      if (ff_pop  && fifo_empty) ff_udf <= 1'b1;
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = RD_DEFAULT;
    if (rf_hit) begin
      rd_mux = rf[idx];
    end else if (sel_tm) begin
      case (idx)
        4'd0:    rd_mux = {29'h0, tm_ctrl};
        4'd1:    rd_mux = tm_load;
        4'd2:    rd_mux = tm_count;
        4'd3:    rd_mux = {31'h0, tm_expired};
        default: rd_mux = RD_DEFAULT;
      endcase
    end else if (sel_ff) begin
      case (idx)
        4'd0:    rd_mux = fifo_empty ? 32'h0 : ff_mem[ff_rp];
        4'd1:    rd_mux = {24'h0, ff_cnt4, ff_udf, ff_ovf, fifo_full, fifo_empty};
        default: rd_mux = RD_DEFAULT;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset)        prdata <= '0;
    else if (rd_setup) prdata <= rd_mux;
  end

endmodule

// File: tb/tb_apb_slave_bank.sv
// Bench for apb_slave_bank: vector table, timer/FIFO sequences, random RF/FIFO traffic vs a queue model.
module tb_apb_slave_bank;
  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  pselx;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        timer_irq, fifo_full, fifo_empty;
`ifdef APB_SEL_CHECK_EN
  logic        sel_err;
`endif

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned last_wr_edge = 0;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  apb_slave_bank dut (
    .hclk(hclk), .hreset(hreset), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .timer_irq(timer_irq),
    .fifo_full(fifo_full),
`ifdef APB_SEL_CHECK_EN
    .sel_err(sel_err),
`endif
    .fifo_empty(fifo_empty)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    pselx = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  // Tasks are entered at a negedge and return at the negedge after the ACCESS edge.
  task automatic apb_wr(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] d);
    pselx = sel; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge hclk) penable = 1'b1;
    @(negedge hclk) idle();
    last_wr_edge = cyc;
  endtask

  task automatic apb_rd(input logic [2:0] sel, input logic [31:0] a,
                        output logic [31:0] d, output int unsigned setup_edge);
    pselx = sel; penable = 1'b0; pwrite = 1'b0; paddr = a; pwdata = '0;
    @(negedge hclk) penable = 1'b1;
    d = prdata;
    setup_edge = cyc;
    @(negedge hclk) idle();
  endtask

  task automatic do_reset();
    hreset = 1'b1; idle();
    @(negedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] d, last_rd, rf_m[16], fq[$], r;
    logic        m_ovf, m_udf;
    int unsigned se, p, m;
    logic [3:0]  ix;

    do_reset();
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    chk("rst_full", {31'h0, fifo_full}, 32'h0);
    chk("rst_empty", {31'h0, fifo_empty}, 32'h1);
`ifdef APB_SEL_CHECK_EN
    chk("rst_sel_err", {31'h0, sel_err}, 32'h0);
`endif

    tbl.push_back('{3'b001, 1'b1, 32'h08, 32'hA5A5_1234});
    tbl.push_back('{3'b001, 1'b0, 32'h08, 32'hA5A5_1234});
    tbl.push_back('{3'b001, 1'b0, 32'h40, 32'h0});
    tbl.push_back('{3'b001, 1'b1, 32'h3C, 32'hDEAD_BEEF});
    tbl.push_back('{3'b001, 1'b0, 32'h3C, 32'hDEAD_BEEF});
    tbl.push_back('{3'b001, 1'b0, 32'h0C, 32'h0});
    tbl.push_back('{3'b010, 1'b1, 32'h04, 32'h7});
    tbl.push_back('{3'b010, 1'b0, 32'h08, 32'h7});
    tbl.push_back('{3'b010, 1'b0, 32'h04, 32'h7});
    tbl.push_back('{3'b010, 1'b0, 32'h00, 32'h0});
    tbl.push_back('{3'b010, 1'b1, 32'h08, 32'h99});
    tbl.push_back('{3'b010, 1'b0, 32'h08, 32'h7});
    tbl.push_back('{3'b010, 1'b0, 32'h10, 32'h0});
    tbl.push_back('{3'b100, 1'b0, 32'h04, 32'h1});
    tbl.push_back('{3'b100, 1'b1, 32'h08, 32'h5});
    tbl.push_back('{3'b100, 1'b0, 32'h04, 32'h1});
`ifndef APB_SEL_CHECK_EN
    tbl.push_back('{3'b011, 1'b0, 32'h08, 32'hA5A5_1234});
    tbl.push_back('{3'b110, 1'b0, 32'h04, 32'h7});
    tbl.push_back('{3'b101, 1'b1, 32'h04, 32'h55});
    tbl.push_back('{3'b001, 1'b0, 32'h04, 32'h55});
    tbl.push_back('{3'b100, 1'b0, 32'h04, 32'h1});
`endif
    last_rd = 32'h0;
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        apb_wr(tbl[i].sel, tbl[i].addr, tbl[i].data);
        chk($sformatf("vec%0d_hold", i), prdata, last_rd);
      end else begin
        apb_rd(tbl[i].sel, tbl[i].addr, d, se);
        chk($sformatf("vec%0d_rd", i), d, tbl[i].data);
        last_rd = tbl[i].data;
      end
    end

    // One-shot timer with irq: COUNT hits 0 five edges after enable, expiry one edge later.
    apb_wr(3'b010, 32'h4, 32'd5);
    apb_wr(3'b010, 32'h0, 32'h5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge hclk);
      chk($sformatf("tm_irq_k%0d", k), {31'h0, timer_irq}, {31'h0, k >= 6});
    end
    apb_rd(3'b010, 32'hC, d, se); chk("tm_status", d, 32'h1);
    apb_rd(3'b010, 32'h0, d, se); chk("tm_ctrl_en_clr", d, 32'h4);
    apb_rd(3'b010, 32'h8, d, se); chk("tm_count_end", d, 32'h0);
    apb_wr(3'b010, 32'hC, 32'h1);
    chk("tm_irq_w1c", {31'h0, timer_irq}, 32'h0);
    apb_rd(3'b010, 32'hC, d, se); chk("tm_status_clr", d, 32'h0);

    // COUNT sampled at random gaps; value latched at a SETUP edge is COUNT m edges after enable.
    apb_wr(3'b010, 32'h4, 32'd5);
    apb_wr(3'b010, 32'h0, 32'h1);
    p = last_wr_edge;
    do begin
      repeat ($urandom_range(0, 1)) @(negedge hclk);
      apb_rd(3'b010, 32'h8, d, se);
      m = se - 1 - p;
      chk($sformatf("tm_cnt_m%0d", m), d, (m >= 5) ? 32'h0 : 32'(5 - m));
    end while (m <= 8);
    apb_rd(3'b010, 32'h0, d, se); chk("tm_oneshot_ctrl", d, 32'h0);
    apb_wr(3'b010, 32'hC, 32'h1);

    apb_wr(3'b010, 32'h4, 32'd2);
    apb_wr(3'b010, 32'h0, 32'h3);
    p = last_wr_edge;
    do begin
      repeat ($urandom_range(0, 1)) @(negedge hclk);
      apb_rd(3'b010, 32'h8, d, se);
      m = se - 1 - p;
      chk($sformatf("tm_ar_m%0d", m), d, 32'(2 - (m % 3)));
    end while (m <= 10);
    apb_rd(3'b010, 32'hC, d, se); chk("tm_ar_status", d, 32'h1);
    chk("tm_ar_noirq", {31'h0, timer_irq}, 32'h0);
    apb_wr(3'b010, 32'h0, 32'h0);
    apb_wr(3'b010, 32'hC, 32'h1);

    // FIFO fill past full, drain past empty.
    for (int i = 0; i < 9; i++) begin
      apb_wr(3'b100, 32'h0, 32'h10 + 32'(i));
      if (i == 6) chk("ff_notfull7", {31'h0, fifo_full}, 32'h0);
      if (i == 7) chk("ff_full8", {31'h0, fifo_full}, 32'h1);
    end
    apb_rd(3'b100, 32'h4, d, se); chk("ff_stat_ovf", d, 32'h86);
    apb_wr(3'b100, 32'h4, 32'h0);
    apb_rd(3'b100, 32'h4, d, se); chk("ff_stat_clr", d, 32'h82);
    for (int i = 0; i < 8; i++) begin
      apb_rd(3'b100, 32'h0, d, se);
      chk($sformatf("ff_pop%0d", i), d, 32'h10 + 32'(i));
    end
    chk("ff_empty", {31'h0, fifo_empty}, 32'h1);
    apb_rd(3'b100, 32'h0, d, se); chk("ff_pop_empty", d, 32'h0);
    apb_rd(3'b100, 32'h4, d, se); chk("ff_stat_udf", d, 32'h09);

    // Random RF/FIFO traffic against a queue/array model.
    do_reset();
    foreach (rf_m[i]) rf_m[i] = '0;
    fq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    for (int n = 0; n < 300; n++) begin
      r  = $urandom;
      ix = r[5:2];
      case ($urandom_range(0, 5))
        0: begin
          d = $urandom;
          apb_wr(3'b001, r, d);
          rf_m[ix] = d;
        end
        1: begin
          apb_rd(3'b001, r, d, se);
          chk($sformatf("rnd%0d_rf", n), d, rf_m[ix]);
        end
        2: begin
          d = $urandom;
          apb_wr(3'b100, 32'h0, d);
          if (fq.size() < 8) fq.push_back(d);
          else m_ovf = 1'b1;
        end
        3: begin
          apb_rd(3'b100, 32'h0, d, se);
          if (fq.size() == 0) begin
            m_udf = 1'b1;
            chk($sformatf("rnd%0d_pop0", n), d, 32'h0);
          end else begin
            chk($sformatf("rnd%0d_pop", n), d, fq.pop_front());
          end
        end
        4: begin
          apb_rd(3'b100, 32'h4, d, se);
          chk($sformatf("rnd%0d_stat", n), d,
              {24'h0, 4'(fq.size()), m_udf, m_ovf, fq.size() == 8, fq.size() == 0});
        end
        default: begin
          apb_wr(3'b100, 32'h4, r);
          m_ovf = 1'b0; m_udf = 1'b0;
        end
      endcase
      chk($sformatf("rnd%0d_flags", n), {30'h0, fifo_full, fifo_empty},
          {30'h0, fq.size() == 8, fq.size() == 0});
    end

    // Reset during the ACCESS of a pop with three entries queued.
    do_reset();
    apb_wr(3'b001, 32'h0C, 32'hCAFE_0001);
    for (int i = 0; i < 3; i++) apb_wr(3'b100, 32'h0, 32'h40 + 32'(i));
    pselx = 3'b100; pwrite = 1'b0; paddr = 32'h0; penable = 1'b0;
    @(negedge hclk);
    penable = 1'b1;
    chk("mid_pre_prdata", prdata, 32'h40);
    hreset = 1'b1;
    @(negedge hclk);
    chk("mid_prdata", prdata, 32'h0);
    chk("mid_empty", {31'h0, fifo_empty}, 32'h1);
    chk("mid_full", {31'h0, fifo_full}, 32'h0);
    hreset = 1'b0; idle();
    @(negedge hclk);
    apb_rd(3'b100, 32'h4, d, se); chk("mid_stat", d, 32'h01);
    apb_rd(3'b001, 32'h0C, d, se); chk("mid_rf", d, 32'h0);

`ifdef APB_SEL_CHECK_EN
    apb_wr(3'b011, 32'h04, 32'h1234);
    chk("sel_err_set", {31'h0, sel_err}, 32'h1);
    apb_rd(3'b001, 32'h04, d, se); chk("sel_rf_nowr", d, 32'h0);
    apb_rd(3'b010, 32'h04, d, se); chk("sel_tm_nowr", d, 32'h0);
    apb_rd(3'b110, 32'h04, d, se); chk("sel_rd_default", d, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_slave_bank.md
Name: apb_slave_bank

Overview:
- Downstream APB target of the AHB-to-APB bridge.
- Consumes the bridge's pselx[2:0], penable, pwrite, paddr and pwdata, and returns prdata.
- Hosts three peripheral windows, one per select line:
  - pselx[0]: 16-word scratch register file.
  - pselx[1]: down-counting timer with interrupt.
  - pselx[2]: write/read data FIFO.
- Zero wait states. No pready. prdata is registered during SETUP so it is stable for the whole ACCESS cycle.

Parameters:
- RF_WORDS, 16, number of 32-bit scratch registers; index = paddr[5:2].
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- RD_DEFAULT, 32'h0000_0000, prdata value for unmapped offsets or no select.

Ports:
- hclk  input  1  single clock, shared with the bridge.
- hreset  input  1  synchronous, active-high reset.
- pselx  input  3  one-hot peripheral select from the bridge.
- penable  input  1  APB access-phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  32  byte address; only paddr[5:2] is decoded.
- pwdata  input  32  write data.
- prdata  output  32  read data, registered.
- timer_irq  output  1  level interrupt, equal to STATUS.expired AND CTRL.irq_en.
- fifo_full  output  1  FIFO full flag.
- fifo_empty  output  1  FIFO empty flag.

Behaviour:
- Reset values (hreset sampled high at a hclk edge):
  - prdata = 0; all scratch registers = 0.
  - Timer CTRL, LOAD, COUNT and STATUS = 0.
  - FIFO pointers and count = 0; sticky flags = 0.
  - Outputs: timer_irq = 0, fifo_full = 0, fifo_empty = 1.
- Reset mid-transfer aborts the transfer: no write commits and no pop occurs.
- Phases:
  - SETUP = psel AND NOT penable.
  - ACCESS = psel AND penable.
- Reads:
  - In the SETUP cycle with pwrite = 0, the block decodes and registers prdata.
  - prdata holds through ACCESS and updates only on the next read SETUP.
  - Read latency: data is valid in the ACCESS cycle.
- Writes and side effects: commit at the hclk edge that ends ACCESS. This covers register writes, FIFO push, FIFO pop and W1C clears.
- Select priority when more than one pselx bit is set (without the optional feature): pselx[0] > pselx[1] > pselx[2].
- Scratch window, pselx[0]:
  - Offsets 0x00..0x3C read and write the full 32-bit word.
  - Indices >= RF_WORDS read RD_DEFAULT; writes to them are ignored.
- Timer window, pselx[1]:
  - 0x0 CTRL: bit0 en, bit1 auto_reload, bit2 irq_en.
  - 0x4 LOAD: read/write. A write to LOAD also copies the value into COUNT.
  - 0x8 COUNT: read-only.
  - 0xC STATUS: bit0 expired; write 1 to clear.
- Timer counting:
  - While en = 1 and COUNT != 0, COUNT decrements by 1 every hclk.
  - When en = 1 and COUNT = 0: expired sets; COUNT reloads from LOAD if auto_reload = 1, otherwise en clears and COUNT stays 0.
  - If a STATUS clear and a new expiry fall in the same cycle, the set wins.
  - If a LOAD write and a decrement fall in the same cycle, the LOAD write wins.
- FIFO window, pselx[2]:
  - 0x0 DATA: a write pushes pwdata; a read returns the head entry, and the pop occurs at the ACCESS edge.
  - 0x4 STATUS, read format: [31:8] zero, [7:4] count, bit3 underflow, bit2 overflow, bit1 full, bit0 empty.
  - Any write to 0x4 clears both sticky bits.
- FIFO boundaries:
  - Push when full: data dropped, overflow set, pointers unchanged.
  - Pop when empty: prdata = 0, underflow set, pointers unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_full and fifo_empty are registered and consistent with count.
- An ACCESS with no matching SETUP (penable high with psel low) is ignored.

Optional Feature:
- Macro: APB_SEL_CHECK_EN.
- Defined:
  - pselx with more than one bit set is illegal: no write, no pop, prdata = RD_DEFAULT.
  - Adds output sel_err (1 bit, reset 0), sticky until hreset.
- Undefined:
  - No sel_err port.
  - Multi-hot pselx resolves by the fixed priority above.

Test Plan:
- Write 32'hA5A5_1234 to pselx=001, paddr=0x08; read back -> prdata = 32'hA5A5_1234 during ACCESS. Read paddr=0x40 -> prdata = 0.
- Timer: write LOAD = 5, then CTRL = 3'b101 -> COUNT steps 5,4,3,2,1,0; expired = 1 and timer_irq = 1 on the cycle after COUNT = 0; en = 0. Write STATUS = 1 -> timer_irq = 0.
- Timer auto-reload: LOAD = 2, CTRL = 3'b011 -> COUNT cycles 2,1,0,2,1,0; expired set at the first wrap; no irq because irq_en = 0.
- FIFO: push 9 words 0x10..0x18 -> fifo_full after the 8th push; STATUS = 8'h86 (count 8, overflow, full). Pop 8 words -> data 0x10..0x17 in order. 9th pop -> prdata = 0, STATUS = 8'h09.
- FIFO wrap: push 6 words, pop 6, push 6 more -> data popped in order, count correct across the pointer wrap, fifo_empty = 1 at the end.
- Assert hreset during the ACCESS of a FIFO pop with 3 entries -> next cycle count = 0, fifo_empty = 1, prdata = 0. With APB_SEL_CHECK_EN, pselx = 011 write -> no register changes and sel_err = 1.
